fifo_control: RTL and testbench

- Pointer and flag controller that sits directly upstream of the 8-entry x 10-bit dual-pointer memory in the transaction layer.
- Converts push/pop requests from the surrounding logic into the memory's wr_en, rd_en, wr_ptr and rd_ptr.
- Tracks occupancy and produces full, empty, almost-full and almost-empty flags plus a sticky overflow/underflow error.
- Data never passes through this block; data_in goes straight to the memory.

---
 rtl/fifo_control.sv | 75 +++++++
 tb/tb_fifo_control.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_control.sv
// Pointer, occupancy and flag controller for the 8x10 transaction FIFO.
// Drives memory strobes/addresses; data bypasses this block.
module fifo_control #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             push,
  input  logic             pop,
  input  logic [CNT_W-1:0] thr_af,
  input  logic [CNT_W-1:0] thr_ae,
  output logic             wr_en,
  output logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             fifo_error
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Occupancy flags and threshold compares, straight off the count register
  always_comb begin
    fifo_full    = (count == FULL_CNT);
    fifo_empty   = (count == '0);
    almost_full  = (count >= thr_af);
    almost_empty = (count <= thr_ae);
  end

  // Accept a request only when it cannot over/underflow; held off in reset
  always_comb begin
    wr_en = push & ~fifo_full & reset_L;
    rd_en = pop & ~fifo_empty & reset_L;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy moves only when exactly one side transfers
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else begin
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error on any rejected request; only reset clears it
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fifo_error <= 1'b0;
    end else if ((push & fifo_full) | (pop & fifo_empty)) begin
      fifo_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_control.sv
// Self-checking bench for fifo_control.
// Reference model predicts strobes and post-edge state via a scoreboard.
module tb_fifo_control;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_L;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] thr_af;
  logic [CNT_W-1:0] thr_ae;
  logic             wr_en;
  logic             rd_en;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             almost_full;
  logic             almost_empty;
  logic             fifo_error;

  fifo_control #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset_L(reset_L),
    .push(push),
    .pop(pop),
    .thr_af(thr_af),
    .thr_ae(thr_ae),
    .wr_en(wr_en),
    .rd_en(rd_en),
    .wr_ptr(wr_ptr),
    .rd_ptr(rd_ptr),
    .count(count),
    .fifo_full(fifo_full),
    .fifo_empty(fifo_empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .fifo_error(fifo_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             full;
    logic             empty;
  } exp_t;

  exp_t sb[$];
  int   n_run = 0;
  int   n_fail = 0;

  int   m_wp, m_rp, m_cnt;
  logic m_err;

  task automatic model_reset();
    m_wp = 0;
    m_rp = 0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic cycle(input logic p, input logic q);
    logic ew, er, eaf, eae;
    exp_t e;
    @(negedge clk);
    push = p;
    pop = q;
    #1;
    ew = p && (m_cnt != DEPTH);
    er = q && (m_cnt != 0);
    n_run++;
    if (wr_en !== ew || rd_en !== er) begin
      n_fail++;
      $display("FAIL strobes: wr_en=%b rd_en=%b, expected %b %b", wr_en, rd_en, ew, er);
    end
    n_run++;
    if (wr_ptr !== PTR_W'(m_wp) || rd_ptr !== PTR_W'(m_rp)) begin
      n_fail++;
      $display("FAIL pre_ptrs: wr_ptr=%0d rd_ptr=%0d, expected %0d %0d", wr_ptr, rd_ptr, m_wp, m_rp);
    end
    if ((p && m_cnt == DEPTH) || (q && m_cnt == 0)) m_err = 1'b1;
    if (ew) m_wp = (m_wp + 1) % DEPTH;
    if (er) m_rp = (m_rp + 1) % DEPTH;
    if (ew && !er) m_cnt = m_cnt + 1;
    if (er && !ew) m_cnt = m_cnt - 1;
    e.wp = PTR_W'(m_wp);
    e.rp = PTR_W'(m_rp);
    e.cnt = CNT_W'(m_cnt);
    e.err = m_err;
    e.full = (m_cnt == DEPTH);
    e.empty = (m_cnt == 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    eaf = (int'(e.cnt) >= int'(thr_af));
    eae = (int'(e.cnt) <= int'(thr_ae));
    n_run++;
    if (wr_ptr !== e.wp || rd_ptr !== e.rp || count !== e.cnt || fifo_error !== e.err) begin
      n_fail++;
      $display("FAIL state: wp=%0d rp=%0d cnt=%0d err=%b, expected %0d %0d %0d %b",
               wr_ptr, rd_ptr, count, fifo_error, e.wp, e.rp, e.cnt, e.err);
    end
    n_run++;
    if (fifo_full !== e.full || fifo_empty !== e.empty ||
        almost_full !== eaf || almost_empty !== eae) begin
      n_fail++;
      $display("FAIL flags: f=%b e=%b af=%b ae=%b, expected %b %b %b %b",
               fifo_full, fifo_empty, almost_full, almost_empty,
               e.full, e.empty, eaf, eae);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    reset_L = 1'b0;
    #2;
    reset_L = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    push = 1'b1;
    pop = 1'b1;
    thr_af = 4'd6;
    thr_ae = 4'd1;
    reset_L = 1'b0;
    #3;
    n_run++;
    if (wr_ptr !== 3'd0 || rd_ptr !== 3'd0 || count !== 4'd0 || fifo_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: wp=%0d rp=%0d cnt=%0d err=%b, expected 0 0 0 0",
               wr_ptr, rd_ptr, count, fifo_error);
    end
    n_run++;
    if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || almost_empty !== 1'b1 ||
        almost_full !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: e=%b f=%b ae=%b af=%b, expected 1 0 1 0",
               fifo_empty, fifo_full, almost_empty, almost_full);
    end
    n_run++;
    if (wr_en !== 1'b0 || rd_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: wr_en=%b rd_en=%b, expected 0 0", wr_en, rd_en);
    end
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    reset_L = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0);
      n_run++;
      if (almost_full !== (i + 1 >= 6)) begin
        n_fail++;
        $display("FAIL fill_af: cnt=%0d af=%b, expected %b", i + 1, almost_full, (i + 1 >= 6));
      end
    end
    n_run++;
    if (wr_ptr !== 3'd0 || count !== 4'd8 || fifo_full !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_end: wp=%0d cnt=%0d full=%b, expected 0 8 1", wr_ptr, count, fifo_full);
    end
  endtask

  task automatic test_full_push_pop();
    cycle(1'b1, 1'b1);
    n_run++;
    if (rd_ptr !== 3'd1 || count !== 4'd7 || fifo_full !== 1'b0 || fifo_error !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pp: rp=%0d cnt=%0d full=%b err=%b, expected 1 7 0 1",
               rd_ptr, count, fifo_full, fifo_error);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    n_run++;
    if (count !== 4'd4 || rd_ptr !== 3'd4) begin
      n_fail++;
      $display("FAIL b2b_pre: cnt=%0d rp=%0d, expected 4 4", count, rd_ptr);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1);
    n_run++;
    if (count !== 4'd4 || wr_ptr !== 3'd4 || rd_ptr !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_end: cnt=%0d wp=%0d rp=%0d, expected 4 4 0", count, wr_ptr, rd_ptr);
    end
  endtask

  task automatic test_underflow();
    pulse_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    n_run++;
    if (fifo_error !== 1'b0 || fifo_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain: err=%b empty=%b, expected 0 1", fifo_error, fifo_empty);
    end
    cycle(1'b0, 1'b1);
    n_run++;
    if (rd_ptr !== 3'd2 || count !== 4'd0 || fifo_error !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow: rp=%0d cnt=%0d err=%b, expected 2 0 1", rd_ptr, count, fifo_error);
    end
  endtask

  task automatic test_thresholds();
    @(negedge clk);
    push = 1'b0;
    pop = 1'b0;
    thr_af = 4'd0;
    thr_ae = 4'd0;
    #1;
    n_run++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL thr_zero: af=%b ae=%b, expected 1 1", almost_full, almost_empty);
    end
    thr_af = 4'd6;
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    thr_af = 4'd3;
    thr_ae = 4'd2;
    #1;
    n_run++;
    if (almost_full !== 1'b1 || almost_empty !== 1'b0) begin
      n_fail++;
      $display("FAIL thr_mid: af=%b ae=%b, expected 1 0", almost_full, almost_empty);
    end
    thr_af = 4'd4;
    thr_ae = 4'd8;
    #1;
    n_run++;
    if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL thr_move: af=%b ae=%b, expected 0 1", almost_full, almost_empty);
    end
    thr_af = 4'd6;
    thr_ae = 4'd1;
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
    @(negedge clk);
    push = 1'b1;
    #2;
    reset_L = 1'b0;
    #1;
    n_run++;
    if (wr_ptr !== 3'd0 || rd_ptr !== 3'd0 || count !== 4'd0 || fifo_error !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: wp=%0d rp=%0d cnt=%0d err=%b, expected 0 0 0 0",
               wr_ptr, rd_ptr, count, fifo_error);
    end
    n_run++;
    if (wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_wr_en: wr_en=%b, expected 0", wr_en);
    end
    @(negedge clk);
    push = 1'b0;
    reset_L = 1'b1;
    model_reset();
    cycle(1'b1, 1'b0);
    n_run++;
    if (wr_ptr !== 3'd1 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL post_reset_push: wp=%0d cnt=%0d, expected 1 1", wr_ptr, count);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_full_push_pop();
    test_back_to_back();
    test_underflow();
    test_thresholds();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
